// File: rtl/str_edge_byte_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// str_edge_byte_fifo : FWFT byte FIFO absorbing the str_edge data_out stream.
// Optional saturating drop counter under STR_EDGE_BYTE_FIFO_DROP_CNT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module str_edge_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
`ifdef STR_EDGE_BYTE_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam int            PW         = $clog2(DEPTH);
  localparam logic [LW-1:0] C_LVL_FULL = LW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  assign w_full  = (level_q == C_LVL_FULL);
  assign w_empty = (level_q == '0);
  // Ready/valid come from registered level only; a pop never frees a slot
  // for the same cycle's input.
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_push && !w_pop) begin
      level_d = level_q + 1'b1;
    end else if (w_pop && !w_push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef STR_EDGE_BYTE_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && w_full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_str_edge_byte_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_str_edge_byte_fifo : vector table, corner sequences and random traffic
// against a queue-based reference model. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_str_edge_byte_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
`ifdef STR_EDGE_BYTE_FIFO_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  str_edge_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty)
`ifdef STR_EDGE_BYTE_FIFO_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the FIFO contents as a plain queue plus a drop tally.
  logic [7:0] model_q[$];
  int         model_drops = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    int         lvl;
    logic [7:0] data;
    int         drops;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, int lvl,
                              logic [7:0] data, int drops);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.lvl = lvl; x.data = data; x.drops = drops;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks the DUT against an explicit level/head/drop expectation.
  task automatic chk_state(input string tag, input int lvl, input logic [7:0] data,
                           input int drops);
    chk({tag, " level"},     int'(level),     lvl);
    chk({tag, " empty"},     int'(empty),     int'(lvl == 0));
    chk({tag, " full"},      int'(full),      int'(lvl == DEPTH));
    chk({tag, " in_ready"},  int'(in_ready),  int'(lvl != DEPTH));
    chk({tag, " out_valid"}, int'(out_valid), int'(lvl != 0));
    if (lvl != 0) chk({tag, " out_data"}, int'(out_data), int'(data));
`ifdef STR_EDGE_BYTE_FIFO_DROP_CNT_EN
    chk({tag, " drop_cnt"}, int'(drop_cnt), drops);
`endif
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] head;
    head = (model_q.size() != 0) ? model_q[0] : 8'h00;
    chk_state(tag, model_q.size(), head, model_drops);
  endtask

  // Drive one cycle of inputs, advance the model on the edge, settle #1.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    bit was_full, was_empty;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (!was_empty && r) void'(model_q.pop_front());
    if (v && !was_full) model_q.push_back(d);
    if (v && was_full && model_drops < 255) model_drops++;
    #1;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_drops = 0;
  endtask

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_state("reset", 0, 8'h00, 0);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("idle", 0, 8'h00, 0);

    // Single byte, fill-and-drop, full with simultaneous pop, drain
    vecs.push_back(mk(1, 8'hAA, 0, 1, 8'hAA, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, 8'hAA, 0, 1, 8'hAA, 0));
    vecs.push_back(mk(1, 8'h55, 0, 2, 8'hAA, 0));
    vecs.push_back(mk(1, 8'h01, 0, 3, 8'hAA, 0));
    vecs.push_back(mk(1, 8'h02, 0, 4, 8'hAA, 0));
    vecs.push_back(mk(1, 8'h03, 0, 4, 8'hAA, 1));
    vecs.push_back(mk(1, 8'hEE, 1, 3, 8'h55, 2));
    vecs.push_back(mk(0, 8'h00, 1, 2, 8'h01, 2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h02, 2));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 2));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 2));
    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].r);
      chk_state($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].data, vecs[i].drops);
    end

    // Wrap-around streaming: level stays at 1, head follows the input by one
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 8'(k), 1'b1);
      chk_state($sformatf("stream%0d", k), 1, 8'(k), 2);
    end
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("stream_end", 0, 8'h00, 2);

    // Reset mid-operation, asserted between edges
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    chk_state("pre_reset", 3, 8'h11, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_state("async_reset", 0, 8'h00, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0);
    chk_state("after_reset", 1, 8'h5A, 0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_model("after_reset_pop");

    // Random traffic in phases biased toward filling and toward draining
    for (int n = 0; n < 600; n++) begin
      int pv, pr;
      pv = ((n / 50) % 2 == 0) ? 80 : 30;
      pr = ((n / 50) % 2 == 0) ? 30 : 80;
      cycle(($urandom_range(99) < pv), 8'($urandom), ($urandom_range(99) < pr));
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
